// File: rtl/eq_coef_pkg.sv
// Shared sizes and FSM state codes for the EQ coefficient loader.
// Used by coeff_load_arbiter and rr_arbiter.
package eq_coef_pkg;

  localparam int NUM_BANDS = 8;
  localparam int TAPS      = 64;
  localparam int COEF_W    = 16;
  localparam int ADDR_W    = 6;
  localparam int BAND_W    = 3;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_SWAP = 2'd2;
  localparam logic [1:0] SWAP      = 2'd3;

  function automatic logic [BAND_W-1:0] oh2idx(
    input logic [NUM_BANDS-1:0] oh
  );
    logic [BAND_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BANDS; i++)
      if (oh[i]) idx = BAND_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter: round-robin from ptr_i upward by default,
// lowest-index fixed priority when ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter
  import eq_coef_pkg::*;
#(
  parameter int N  = NUM_BANDS,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // lowest requesting index wins
  always_comb begin
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) grant_o = N'(1) << i;
  end
`else
  // first requester at or above the pointer, wrapping
  always_comb begin
    logic found;
    int   idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/coeff_load_arbiter.sv
// Coefficient-RAM write-port arbiter with shadow-bank swap at pass end.
// Build option: ARB_FIXED_PRIORITY_EN selects fixed priority arbitration.
module coeff_load_arbiter
  import eq_coef_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_enable,
  input  logic                        i_phase_63,
  input  logic [NUM_BANDS-1:0]        i_req,
  input  logic [NUM_BANDS*COEF_W-1:0] i_band_data,
  output logic [NUM_BANDS-1:0]        o_grant,
  output logic [ADDR_W-1:0]           o_rd_addr,
  output logic                        o_wr_en,
  output logic [BAND_W-1:0]           o_wr_band,
  output logic [ADDR_W-1:0]           o_wr_addr,
  output logic [COEF_W-1:0]           o_wr_data,
  output logic [NUM_BANDS-1:0]        o_bank_swap,
  output logic [NUM_BANDS-1:0]        o_ack,
  output logic                        o_busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TAPS);

  logic [1:0]           state_q, state_d;
  logic [NUM_BANDS-1:0] grant_q, arb_gnt;
  logic [BAND_W-1:0]    gidx_q, ptr_w;
  logic [CNT_W-1:0]     cnt_q;
  logic                 wr_en_q;
  logic [BAND_W-1:0]    wr_band_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [COEF_W-1:0]    wr_data_q;

`ifdef ARB_FIXED_PRIORITY_EN
  assign ptr_w = '0;
`else
  logic [BAND_W-1:0] ptr_q;
  assign ptr_w = ptr_q;
`endif

  rr_arbiter #(.N(NUM_BANDS)) u_arb (
    .req_i   (i_req),
    .ptr_i   (ptr_w),
    .grant_o (arb_gnt)
  );

  // state register, frozen while clk_enable is low
  always_ff @(posedge clk) begin
    if (rst)             state_q <= IDLE;
    else if (clk_enable) state_q <= state_d;
  end

  // next state; LOAD ends once the last write is on the port
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (|i_req) state_d = LOAD;
      LOAD:      if (cnt_q == CNT_END) state_d = WAIT_SWAP;
      WAIT_SWAP: if (i_phase_63) state_d = SWAP;
      SWAP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // grant, tap counter, write pipeline and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_band_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q     <= '0;
`endif
    end else if (clk_enable) begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|i_req) begin
            grant_q <= arb_gnt;
            gidx_q  <= oh2idx(arb_gnt);
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (cnt_q != CNT_END) begin
            wr_en_q   <= 1'b1;
            wr_band_q <= gidx_q;
            wr_addr_q <= cnt_q[ADDR_W-1:0];
            wr_data_q <=
              i_band_data[int'(gidx_q)*COEF_W +: COEF_W];
            cnt_q     <= cnt_q + 1'b1;
          end
        end
        SWAP: begin
          grant_q <= '0;
          cnt_q   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
          ptr_q   <= (gidx_q == BAND_W'(NUM_BANDS - 1)) ?
                     '0 : gidx_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // pulse outputs are suppressed on stalled cycles and reappear after
  always_comb begin
    o_busy      = (state_q != IDLE);
    o_wr_en     = wr_en_q & clk_enable;
    o_bank_swap = '0;
    o_ack       = '0;
    if (clk_enable && state_q == SWAP) begin
      o_bank_swap = grant_q;
      o_ack       = grant_q;
    end
  end

  assign o_grant   = grant_q;
  assign o_rd_addr = cnt_q[ADDR_W-1:0];
  assign o_wr_band = wr_band_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;

endmodule

// File: tb/tb_coeff_load_arbiter.sv
// Bench for coeff_load_arbiter: directed cases plus random traffic,
// checked every cycle against a transaction-timeline model.
module tb_coeff_load_arbiter;
  import eq_coef_pkg::*;

  localparam int NB = NUM_BANDS;

  logic                 clk = 1'b0;
  logic                 rst, clk_enable, i_phase_63;
  logic [NB-1:0]        i_req;
  logic [NB*COEF_W-1:0] i_band_data;
  logic [NB-1:0]        o_grant, o_bank_swap, o_ack;
  logic [ADDR_W-1:0]    o_rd_addr, o_wr_addr;
  logic                 o_wr_en, o_busy;
  logic [BAND_W-1:0]    o_wr_band;
  logic [COEF_W-1:0]    o_wr_data;

  always #5 clk = ~clk;

  coeff_load_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .clk_enable  (clk_enable),
    .i_phase_63  (i_phase_63),
    .i_req       (i_req),
    .i_band_data (i_band_data),
    .o_grant     (o_grant),
    .o_rd_addr   (o_rd_addr),
    .o_wr_en     (o_wr_en),
    .o_wr_band   (o_wr_band),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_bank_swap (o_bank_swap),
    .o_ack       (o_ack),
    .o_busy      (o_busy)
  );

  function automatic logic [COEF_W-1:0] coef(int b, int a);
    return {4'h0, 4'(b ^ 3), 2'b00, 6'(a)};
  endfunction

  always_comb begin
    i_band_data = '0;
    for (int b = 0; b < NB; b++)
      i_band_data[b*COEF_W +: COEF_W] = coef(b, int'(o_rd_addr));
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int arb(logic [NB-1:0] r, int p);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NB; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NB; k++) if (r[(p + k) % NB]) return (p + k) % NB;
`endif
    return -1;
  endfunction

  // model: e counts enabled cycles since the grant was taken
  bit m_busy = 0, m_swap = 0, started = 0;
  int m_owner = 0, m_e = 0, m_ptr = 0;

  int cyc = 0, nwr = 0, nswap = 0, seq_err = 0, exp_next = 0;
  int last_wr_cyc = 0, swap_cyc = 0;
  logic [COEF_W-1:0] first_data, last_data;
  logic [NB-1:0] last_swap, prev_grant = '0;
  int ack_cnt [NB];
  int gq[$];

  initial for (int b = 0; b < NB; b++) ack_cnt[b] = 0;

  always @(negedge clk) begin : mon
    logic [NB-1:0] eg, es;
    bit ew;
    int w;
    cyc++;
    if (started) begin
      eg = m_busy ? (NB'(1) << m_owner) : '0;
      chk("grant", 32'(o_grant), 32'(eg));
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("rd_addr", 32'(o_rd_addr),
          (m_busy && m_e <= TAPS) ? 32'(m_e - 1) : 32'd0);
      ew = clk_enable && m_busy && m_e >= 2 && m_e <= TAPS + 1;
      chk("wr_en", 32'(o_wr_en), 32'(ew));
      if (ew) begin
        chk("wr_band", 32'(o_wr_band), 32'(m_owner));
        chk("wr_addr", 32'(o_wr_addr), 32'(m_e - 2));
        chk("wr_data", 32'(o_wr_data), 32'(coef(m_owner, m_e - 2)));
      end
      es = (clk_enable && m_swap) ? eg : '0;
      chk("bank_swap", 32'(o_bank_swap), 32'(es));
      chk("ack", 32'(o_ack), 32'(es));
    end
    if (o_wr_en === 1'b1) begin
      if (nwr == 0) first_data = o_wr_data;
      if (int'(o_wr_addr) != exp_next) seq_err++;
      exp_next  = int'(o_wr_addr) + 1;
      last_data = o_wr_data;
      nwr++;
      if (o_wr_addr == 6'd63) last_wr_cyc = cyc;
    end
    if (o_bank_swap !== '0 && !$isunknown(o_bank_swap)) begin
      nswap++;
      last_swap = o_bank_swap;
      swap_cyc  = cyc;
    end
    for (int b = 0; b < NB; b++) if (o_ack[b] === 1'b1) ack_cnt[b]++;
    if (!$isunknown(o_grant) && o_grant != '0 && prev_grant == '0)
      for (int b = 0; b < NB; b++) if (o_grant[b]) gq.push_back(b);
    if (!$isunknown(o_grant)) prev_grant = o_grant;
    if (rst) begin
      m_busy = 0; m_swap = 0; m_ptr = 0; m_e = 0; started = 1;
    end else if (clk_enable) begin
      if (!m_busy) begin
        w = arb(i_req, m_ptr);
        if (w >= 0) begin m_busy = 1; m_owner = w; m_e = 1; end
      end else if (m_swap) begin
        m_busy = 0; m_swap = 0; m_ptr = (m_owner + 1) % NB;
      end else begin
        if (m_e >= TAPS + 2 && i_phase_63) m_swap = 1;
        m_e++;
      end
    end
  end

  bit auto_ph = 1;
  int pc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ph) i_phase_63 = (pc % 64 == 63);
    pc++;
  endtask

  task automatic clr_mon();
    nwr = 0; nswap = 0; seq_err = 0; exp_next = 0; last_swap = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; clr_mon();
  endtask

  task automatic wait_ack(int b, string nm);
    int c0;
    c0 = ack_cnt[b];
    for (int i = 0; i < 400 && ack_cnt[b] == c0; i++) tick();
    chk({nm, "_ack_seen"}, 32'(ack_cnt[b] != c0), 32'd1);
  endtask

  task automatic wait_rd(int a, string nm);
    for (int i = 0; i < 200 && !(o_busy && o_rd_addr == 6'(a)); i++)
      tick();
    chk({nm, "_reach_addr"}, 32'(o_rd_addr), 32'(a));
  endtask

  int seen [NB];

  initial begin
    rst = 1'b1; clk_enable = 1'b1; i_phase_63 = 1'b0; i_req = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_swap", 32'(o_bank_swap), 32'd0);

    // 1: single request from band 2
    clr_mon();
    i_req = 8'h04;
    wait_ack(2, "t1");
    i_req = '0;
    repeat (4) tick();
    chk("t1_nwr", 32'(nwr), 32'd64);
    chk("t1_first", 32'(first_data), 32'h0100);
    chk("t1_last", 32'(last_data), 32'h013F);
    chk("t1_seq", 32'(seq_err), 32'd0);
    chk("t1_nswap", 32'(nswap), 32'd1);
    chk("t1_swapbit", 32'(last_swap), 32'h04);

    // 2: all bands contending
    do_reset();
    gq.delete();
    i_req = '1;
    for (int i = 0; i < 3000 && gq.size() < 9; i++) tick();
    i_req = '0;
    chk("t2_ngrants", 32'(gq.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < gq.size(); i++)
`ifdef ARB_FIXED_PRIORITY_EN
      chk("t2_order", 32'(gq[i]), 32'd0);
`else
      chk("t2_order", 32'(gq[i]), 32'(i % NB));
`endif

    // 3: pass boundary coincident with the last write
    do_reset();
    auto_ph = 0; i_phase_63 = 1'b0;
    i_req = 8'h10;
    for (int i = 0; i < 200 && !(o_wr_en && o_wr_addr == 6'd63); i++)
      tick();
    chk("t3_lastwr", 32'(o_wr_addr), 32'd63);
    i_phase_63 = 1'b1; tick(); i_phase_63 = 1'b0;
    repeat (63) tick();
    i_phase_63 = 1'b1; tick(); i_phase_63 = 1'b0;
    wait_ack(4, "t3");
    i_req = '0;
    chk("t3_nswap", 32'(nswap), 32'd1);
    chk("t3_delay", 32'(swap_cyc - last_wr_cyc), 32'd65);
    auto_ph = 1;

    // 4: stall at tap 10
    do_reset();
    i_req = 8'h02;
    wait_rd(10, "t4");
    clk_enable = 1'b0;
    repeat (5) tick();
    clk_enable = 1'b1;
    wait_ack(1, "t4");
    i_req = '0;
    chk("t4_nwr", 32'(nwr), 32'd64);
    chk("t4_seq", 32'(seq_err), 32'd0);

    // 5: reset mid-load
    do_reset();
    i_req = 8'h08;
    wait_rd(30, "t5");
    rst = 1'b1; i_req = '0;
    tick();
    rst = 1'b0;
    chk("t5_grant", 32'(o_grant), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_wr_en", 32'(o_wr_en), 32'd0);
    nswap = 0;
    repeat (200) tick();
    chk("t5_nswap", 32'(nswap), 32'd0);

    // 6: band 5 drops its request at tap 3
    do_reset();
    i_req = 8'h20;
    wait_rd(3, "t6");
    i_req = '0;
    wait_ack(5, "t6");
    chk("t6_nwr", 32'(nwr), 32'd64);
    chk("t6_nswap", 32'(nswap), 32'd1);
    chk("t6_swapbit", 32'(last_swap), 32'h20);

    // random traffic
    do_reset();
    auto_ph = 0;
    for (int b = 0; b < NB; b++) seen[b] = ack_cnt[b];
    for (int n = 0; n < 5000; n++) begin
      clk_enable = ($urandom_range(0, 9) != 0);
      i_phase_63 = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
      for (int b = 0; b < NB; b++) begin
        if (ack_cnt[b] != seen[b]) begin
          seen[b] = ack_cnt[b];
          if ($urandom_range(0, 1) == 0) i_req[b] = 1'b0;
        end else if (!i_req[b] && $urandom_range(0, 39) == 0) begin
          i_req[b] = 1'b1;
        end else if ($urandom_range(0, 499) == 0) begin
          i_req[b] = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0; clk_enable = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
